// File: rtl/core_bus_arbiter_if.sv
// Signal bundle between the arbiter, the fetch/memory requesters and the cbus memory bridge.
// The master modport is the arbiter's view; the slave modport is the core + bridge side.
interface core_bus_arbiter_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  logic        creq_valid;
  logic        creq_is_write;
  logic [2:0]  creq_size;
  logic [63:0] creq_addr;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic [7:0]  creq_len;
  logic [1:0]  creq_burst;
  logic        cresp_ready;
  logic        cresp_last;
  logic [63:0] cresp_data;

  modport master (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe, creq_data,
    output creq_len, creq_burst,
    input  cresp_ready, cresp_last, cresp_data
  );

  modport slave (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe, creq_data,
    input  creq_len, creq_burst,
    output cresp_ready, cresp_last, cresp_data
  );
endinterface

// File: rtl/core_bus_arbiter.sv
// Arbitrates ibus and dbus onto one single-beat cbus master port. dbus wins ties unless ibus
// has been passed over STARVE_LIMIT times in a row.
module core_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                reset,
  core_bus_arbiter_if.master bus
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveLimitCnt = CntW'(STARVE_LIMIT);
  localparam logic [2:0] MSize4     = 3'b010;
  localparam logic [7:0] MLen1      = 8'd0;
  localparam logic [1:0] BurstFixed = 2'b00;

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_starve_cnt;
  logic            r_creq_valid;
  logic            r_is_write;
  logic [2:0]      r_size;
  logic [63:0]     r_addr;
  logic [7:0]      r_strobe;
  logic [63:0]     r_data;

  logic w_done;
  logic w_grant_d;
  logic w_resp_i;
  logic w_resp_d;

  // Responses are gated by reset so a late bridge beat never leaks out during reset.
  always_comb begin
    w_done    = bus.cresp_ready & bus.cresp_last & ~reset;
    w_resp_i  = (r_state == StBusyI) & w_done;
    w_resp_d  = (r_state == StBusyD) & w_done;
    w_grant_d = bus.dreq_valid & ~(bus.ireq_valid & (r_starve_cnt == StarveLimitCnt));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_starve_cnt <= '0;
      r_creq_valid <= 1'b0;
      r_is_write   <= 1'b0;
      r_size       <= '0;
      r_addr       <= '0;
      r_strobe     <= '0;
      r_data       <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_grant_d) begin
            r_state      <= StBusyD;
            r_creq_valid <= 1'b1;
            r_is_write   <= |bus.dreq_strobe;
            r_size       <= bus.dreq_size;
            r_addr       <= bus.dreq_addr;
            r_strobe     <= bus.dreq_strobe;
            r_data       <= bus.dreq_data;
            if (!bus.ireq_valid) begin
              r_starve_cnt <= '0;
            end else if (r_starve_cnt != StarveLimitCnt) begin
              r_starve_cnt <= r_starve_cnt + CntW'(1);
            end
          end else if (bus.ireq_valid) begin
            r_state      <= StBusyI;
            r_creq_valid <= 1'b1;
            r_is_write   <= 1'b0;
            r_size       <= MSize4;
            r_addr       <= bus.ireq_addr;
            r_strobe     <= '0;
            r_data       <= '0;
            r_starve_cnt <= '0;
          end
        end
        StBusyI, StBusyD: begin
          // ready without last is tolerated and simply keeps the request up.
          if (w_done) begin
            r_state      <= StIdle;
            r_creq_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= StIdle;
          r_creq_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.creq_valid    = r_creq_valid;
  assign bus.creq_is_write = r_is_write;
  assign bus.creq_size     = r_size;
  assign bus.creq_addr     = r_addr;
  assign bus.creq_strobe   = r_strobe;
  assign bus.creq_data     = r_data;
  assign bus.creq_len      = MLen1;
  assign bus.creq_burst    = BurstFixed;

  assign bus.iresp_addr_ok = w_resp_i;
  assign bus.iresp_data_ok = w_resp_i;
  assign bus.iresp_data    = !w_resp_i ? 32'd0 :
                             (r_addr[2] ? bus.cresp_data[63:32] : bus.cresp_data[31:0]);

  assign bus.dresp_addr_ok = w_resp_d;
  assign bus.dresp_data_ok = w_resp_d;
  assign bus.dresp_data    = w_resp_d ? bus.cresp_data : 64'd0;

endmodule
